// File: rtl/stepper_move_sequencer_pkg.sv
// Shared definitions for the stepper move sequencer: the half-step coil
// pattern table, the sequencer state encoding and the direction constants.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SETTLE = 2'd2
  } seq_state_e;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Unipolar half-step sequence, indexed by the 3-bit phase
  localparam logic [3:0] HALF_STEP_TABLE [8] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };

endpackage

// File: rtl/stepper_move_sequencer_if.sv
// Command and status bundle between a move-command source (master) and the
// stepper move sequencer (slave).
interface stepper_move_sequencer_if #(
  parameter int COUNT_W  = 16,
  parameter int PERIOD_W = 20,
  parameter int POS_W    = 24
);

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [COUNT_W-1:0]         cmd_steps;
  logic                       cmd_dir;
  logic [PERIOD_W-1:0]        cmd_period;
  logic                       abort;
  logic [3:0]                 coil_out;
  logic                       busy;
  logic                       done;
  logic                       aborted;
  logic [COUNT_W-1:0]         steps_left;
  logic signed [POS_W-1:0]    position;

  modport master (
    output cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    input  cmd_ready, coil_out, busy, done, aborted, steps_left, position
  );

  modport slave (
    input  cmd_valid, cmd_steps, cmd_dir, cmd_period, abort,
    output cmd_ready, coil_out, busy, done, aborted, steps_left, position
  );

endinterface

// File: rtl/stepper_move_sequencer_step_rate_timer.sv
// Loadable period counter: counts 0..period-1 while enabled and flags the
// terminal count with a one-cycle tick. Used both as the step-rate timer and
// as the post-move settle dwell timer.
module step_rate_timer #(
  parameter int PERIOD_W = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count_q;

  assign tick = enable && (count_q == period - PERIOD_W'(1));

  // Advance the count, restarting from zero on clear or at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear || tick) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/stepper_move_sequencer.sv
// Command-driven stepper sequencer: accepts one move at a time, steps the
// half-step coil pattern at the commanded rate, tracks absolute position and
// pulses done after a settle dwell (or immediately on abort).
module stepper_move_sequencer
  import stepper_pkg::*;
#(
  parameter int COUNT_W       = 16,
  parameter int PERIOD_W      = 20,
  parameter int POS_W         = 24,
  parameter int MIN_PERIOD    = 100,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stepper_move_sequencer_if.slave bus
);

  seq_state_e              state;
  logic [COUNT_W-1:0]      steps_left_q;
  logic [PERIOD_W-1:0]     period_q;
  logic                    dir_q;
  logic [2:0]              phase_q;
  logic [2:0]              next_phase;
  logic [3:0]              coil_q;
  logic signed [POS_W-1:0] pos_q;
  logic                    done_q;
  logic                    aborted_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    tick;
  logic                    last_step;
  logic                    timer_clear;
  logic                    timer_enable;
  logic [PERIOD_W-1:0]     timer_period;
  logic [PERIOD_W-1:0]     eff_period;

  assign eff_period   = (bus.cmd_period < PERIOD_W'(MIN_PERIOD)) ? PERIOD_W'(MIN_PERIOD)
                                                                 : bus.cmd_period;
  assign next_phase   = (dir_q == DIR_FWD) ? phase_q + 3'd1 : phase_q - 3'd1;
  assign last_step    = (state == RUN) && tick && !bus.abort && (steps_left_q == COUNT_W'(1));
  assign timer_clear  = (state == IDLE) || last_step;
  assign timer_enable = (state != IDLE);
  assign timer_period = (state == SETTLE) ? PERIOD_W'(SETTLE_CYCLES) : period_q;

  step_rate_timer #(.PERIOD_W(PERIOD_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .period (timer_period),
    .tick   (tick)
  );

  // Move sequencing: accept, step on timer ticks, settle, abort handling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      steps_left_q <= '0;
      period_q     <= '0;
      dir_q        <= DIR_FWD;
      phase_q      <= 3'd0;
      coil_q       <= 4'b0000;
      pos_q        <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            steps_left_q <= bus.cmd_steps;
            period_q     <= eff_period;
            dir_q        <= bus.cmd_dir;
            coil_q       <= HALF_STEP_TABLE[phase_q];
            ready_q      <= 1'b0;
            busy_q       <= 1'b1;
            state        <= (bus.cmd_steps == '0) ? SETTLE : RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end else if (tick) begin
            phase_q      <= next_phase;
            coil_q       <= HALF_STEP_TABLE[next_phase];
            pos_q        <= (dir_q == DIR_REV) ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
            steps_left_q <= steps_left_q - COUNT_W'(1);
            if (steps_left_q == COUNT_W'(1)) begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (bus.abort || tick) begin
            state     <= IDLE;
            done_q    <= 1'b1;
            aborted_q <= bus.abort;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
  assign bus.coil_out   = coil_q;
  assign bus.steps_left = steps_left_q;
  assign bus.position   = pos_q;

endmodule

// File: tb/tb_stepper_move_sequencer.sv
// Scoreboard bench for the stepper move sequencer. The driver computes each
// move's expected coil events and completion from the step-timing rules and
// queues them; the monitor compares them as the DUT presents them.
module tb_stepper_move_sequencer;

  localparam int SETTLE = 1000;
  localparam int MINP   = 100;

  typedef struct {
    longint     cyc;
    logic [3:0] coil;
  } step_ev_t;

  typedef struct {
    longint      cyc;
    logic        aborted;
    logic [23:0] pos;
    logic [15:0] left;
    logic [3:0]  coil;
  } done_ev_t;

  logic clk = 1'b0;
  logic rst_n;
  longint cyc = 0;
  bit mon_on = 1'b0;
  int n_compared = 0;
  int n_failed = 0;

  logic [3:0] pat_tab [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                              4'b0100, 4'b1100, 4'b1000, 4'b1001};

  step_ev_t step_q[$];
  done_ev_t done_q[$];
  longint   accept_q[$];

  int          m_phase;
  logic [23:0] m_pos;
  logic [3:0]  m_coil;
  logic [3:0]  last_coil;

  stepper_move_sequencer_if bus ();

  stepper_move_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic reportUnexpected(input string name, input logic [63:0] act);
    n_compared++;
    n_failed++;
    $display("[TB] FAIL %s at cycle %0d: actual=%0h required=no event", name, cyc, act);
  endtask

  // Monitor: reset values, accept response, coil events and completions
  always @(negedge clk or negedge rst_n) begin
    step_ev_t s;
    done_ev_t d;
    longint   t;
    if (!rst_n) begin
      #1;
      if (cyc > 0) begin
        checkOutput("reset_coil", bus.coil_out, 0);
        checkOutput("reset_position", {40'b0, bus.position}, 0);
        checkOutput("reset_steps_left", bus.steps_left, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_ready", bus.cmd_ready, 1);
        checkOutput("reset_done", {bus.done, bus.aborted}, 0);
      end
      last_coil = 4'b0000;
    end else if (mon_on) begin
      if (accept_q.size() != 0 && cyc >= accept_q[0]) begin
        t = accept_q.pop_front();
        checkOutput("accept_cycle", cyc, t);
        checkOutput("accept_busy", bus.busy, 1);
        checkOutput("accept_ready", bus.cmd_ready, 0);
      end
      if (bus.coil_out !== last_coil) begin
        if (step_q.size() == 0) begin
          reportUnexpected("coil_change", bus.coil_out);
        end else begin
          s = step_q.pop_front();
          checkOutput("step_cycle", cyc, s.cyc);
          checkOutput("step_coil", bus.coil_out, s.coil);
        end
        last_coil = bus.coil_out;
      end
      if (bus.done) begin
        if (done_q.size() == 0) begin
          reportUnexpected("done", 1);
        end else begin
          d = done_q.pop_front();
          checkOutput("done_cycle", cyc, d.cyc);
          checkOutput("done_aborted", bus.aborted, d.aborted);
          checkOutput("done_position", {40'b0, bus.position}, {40'b0, d.pos});
          checkOutput("done_steps_left", bus.steps_left, d.left);
          checkOutput("done_coil", bus.coil_out, d.coil);
          checkOutput("done_ready", bus.cmd_ready, 1);
        end
      end
    end
  end

  // Issue one move and queue its expected response; abort_at is the number
  // of edges after the accept edge at which abort takes effect (0 = none)
  task automatic applyStimulus(input int steps, input int dir, input int period, input int abort_at);
    int     eff;
    int     taken;
    int     n;
    longint t0;
    longint done_at;
    n = 0;
    while (!bus.cmd_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      $display("[TB] FAIL ready_timeout at cycle %0d: cmd_ready never rose", cyc);
      $fatal(1, "[TB] stopping");
    end
    eff = (period < MINP) ? MINP : period;
    bus.cmd_valid  = 1'b1;
    bus.cmd_steps  = 16'(steps);
    bus.cmd_dir    = dir[0];
    bus.cmd_period = 20'(period);
    t0 = cyc + 1;
    accept_q.push_back(t0);
    if (m_coil != pat_tab[m_phase]) begin
      m_coil = pat_tab[m_phase];
      step_q.push_back('{cyc: t0, coil: m_coil});
    end
    if (abort_at == 0) begin
      taken   = steps;
      done_at = t0 + longint'(steps) * eff + SETTLE;
    end else begin
      taken   = (abort_at - 1) / eff;
      if (taken > steps) taken = steps;
      done_at = t0 + abort_at;
    end
    for (int i = 1; i <= taken; i++) begin
      m_phase = (m_phase + (dir[0] ? 7 : 1)) % 8;
      m_pos   = dir[0] ? m_pos - 24'd1 : m_pos + 24'd1;
      m_coil  = pat_tab[m_phase];
      step_q.push_back('{cyc: t0 + longint'(i) * eff, coil: m_coil});
    end
    done_q.push_back('{cyc: done_at, aborted: (abort_at != 0), pos: m_pos,
                       left: 16'(steps - taken), coil: m_coil});
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (abort_at != 0) begin
      while (cyc < t0 + abort_at - 1) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
    end
  endtask

  task automatic waitQuiet();
    int n;
    n = 0;
    while (!(bus.cmd_ready && step_q.size() == 0 && done_q.size() == 0) && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) begin
      $display("[TB] FAIL quiet_timeout at cycle %0d: %0d steps, %0d dones pending",
               cyc, step_q.size(), done_q.size());
      $fatal(1, "[TB] stopping");
    end
  endtask

  task automatic doReset();
    mon_on = 1'b0;
    @(negedge clk);
    step_q.delete();
    done_q.delete();
    accept_q.delete();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    m_phase = 0;
    m_pos   = '0;
    m_coil  = 4'b0000;
    mon_on  = 1'b1;
  endtask

  // Directed moves, random moves, then a reset in the middle of a move
  initial begin
    int st, dr, pr, ab;
    rst_n          = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.cmd_steps  = '0;
    bus.cmd_dir    = 1'b0;
    bus.cmd_period = '0;
    bus.abort      = 1'b0;
    m_phase = 0;
    m_pos   = '0;
    m_coil  = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    $display("[TB] forward 3 steps at period 200");
    applyStimulus(3, 0, 200, 0);
    waitQuiet();
    doReset();

    $display("[TB] reverse 2 steps from phase 0");
    applyStimulus(2, 1, 150, 0);
    $display("[TB] short period clamped to minimum");
    applyStimulus(4, 0, 5, 0);
    $display("[TB] abort on the second step tick");
    applyStimulus(10, 1, 120, 240);

    $display("[TB] command pulsed while busy");
    applyStimulus(2, 0, 100, 0);
    repeat (30) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_steps = 16'd7;
    @(negedge clk);
    bus.cmd_valid = 1'b0;

    $display("[TB] zero-step command");
    applyStimulus(0, 0, 300, 0);

    $display("[TB] random moves");
    for (int k = 0; k < 8; k++) begin
      st = $urandom_range(6, 0);
      dr = $urandom_range(1, 0);
      pr = $urandom_range(250, 0);
      ab = 0;
      if ($urandom_range(3, 0) == 0) begin
        ab = $urandom_range(st * ((pr < MINP) ? MINP : pr) + SETTLE, 1);
      end
      applyStimulus(st, dr, pr, ab);
    end
    waitQuiet();

    $display("[TB] reset in the middle of a move");
    applyStimulus(10, 0, 100, 0);
    repeat (350) @(negedge clk);
    doReset();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/stepper_move_sequencer.md
# stepper_move_sequencer

Command-driven sequencer for the unipolar stepper drive: accepts one move at a time (step count, direction, step period) over a valid/ready handshake and advances the 8-entry half-step coil pattern at the commanded rate. It reports absolute position and signals completion. It replaces free-running divided-clock stepping: all logic runs on the system clock, and steps are qualified by an internal rate timer.

## Interface
- COUNT_W, 16, width of step count and steps_left
- PERIOD_W, 20, width of step period in clk cycles
- POS_W, 24, width of signed absolute position
- MIN_PERIOD, 100, lower clamp on step period (cycles)
- SETTLE_CYCLES, 1000, dwell after the last step, coils held energized

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately
- cmd_valid  in  1  move command present
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE
- cmd_steps  in  COUNT_W  number of half-steps to move
- cmd_dir  in  1  0 = forward (phase +1), 1 = reverse (phase −1)
- cmd_period  in  PERIOD_W  clk cycles per half-step
- abort  in  1  stop the current move at the next edge
- coil_out  out  4  coil drive pattern
- busy  out  1  high in RUN and SETTLE
- done  out  1  one-cycle pulse at end of move (normal or aborted)
- aborted  out  1  valid with done; 1 = move ended by abort
- steps_left  out  COUNT_W  remaining half-steps
- position  out  POS_W  signed absolute half-step position

## Operation
- Half-step table, indexed by 3-bit phase 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
- Reset values: state IDLE, phase 0, coil_out 0000 (de-energized), cmd_ready 1, busy 0, done 0, aborted 0, steps_left 0, position 0, timer 0.
- States: IDLE, RUN, SETTLE.
- IDLE: accept on cmd_valid && cmd_ready. Latch steps, dir, and eff_period = max(cmd_period, MIN_PERIOD). Clear the timer. Set coil_out = table[phase].
  - steps = 0: go to SETTLE.
  - otherwise: go to RUN.
- RUN: the timer counts 0..eff_period−1. At terminal count a step occurs:
  - phase ±1 mod 8 (wrap 7→0 forward, 0→7 reverse)
  - coil_out = table[new phase] on the same edge
  - position ±1, two's-complement wrap
  - steps_left −1
  - when steps_left reaches 0, go to SETTLE with the timer cleared.
- SETTLE: count SETTLE_CYCLES cycles, then pulse done (aborted=0) and go to IDLE.
- abort in RUN or SETTLE: on the next edge go to IDLE, pulse done with aborted=1, leave steps_left as is, and hold coil_out at its current pattern. abort in IDLE is ignored.
- Simultaneous abort and step terminal count: abort wins and no step is taken.
- coil_out keeps the last pattern in IDLE after any move. It returns to 0000 only on reset.
- cmd inputs are ignored while busy.

## Timing
- Accept edge T0: busy=1 and cmd_ready=0 from T0+1, and coil_out is energized at T0+1.
- First step at T0 + eff_period. Subsequent steps every eff_period cycles.
- After the last step at Tn: done is high during cycle Tn + SETTLE_CYCLES + 1, and cmd_ready=1 in the same cycle.
- Zero-step command: done follows SETTLE_CYCLES+1 cycles after accept.
- Back-to-back moves: a new command can be accepted in the cycle done is high. The phase continues from the previous move.
- Reset deasserted mid-move: restarts in IDLE with all reset values and coils off.

## Structure
- Shared package stepper_pkg holds:
  - the half-step pattern table (8×4 constant)
  - the state enum (IDLE/RUN/SETTLE)
  - the DIR_FWD/DIR_REV constants
- One sub-module, step_rate_timer:
  - loadable period counter with clear
  - emits a one-cycle tick at terminal count
  - reused for the SETTLE dwell with a period of SETTLE_CYCLES.

## Test plan
- Reset, then cmd steps=3, dir=0, period=200 → coil_out 0001, then 0011 @T0+200, 0010 @+400, 0110 @+600; position=3; done at T0+600+SETTLE_CYCLES+1.
- From phase 0, steps=2, dir=1, period=150 → coil_out 1001 then 1000; position=−2 (all ones in low bits wrap correct); steps_left 0.
- period=5 with MIN_PERIOD=100 → steps spaced 100 cycles.
- abort asserted on the same cycle as the 2nd step tick of a 10-step move → only 1 step taken, done+aborted=1, steps_left=9, coil_out held.
- cmd_valid pulsed while busy → ignored, no second move; steps=0 command → no coil change beyond energize, done after SETTLE_CYCLES+1.
- reset driven low mid-RUN between clock edges → outputs immediately at reset values (coil_out 0000, position 0).
